// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/busy/done handshake.
// Single-cycle ops (PASS/ADD/SUB/AND/OR/XOR) complete one cycle after accept.
// MUL is an unsigned iterative shift-add taking WIDTH iterations.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             alu_en,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] alu_operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               mul_last;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res_d;
    logic               c_d;
    logic               v_d;

    assign accept   = start && alu_en && (state == S_IDLE);
    assign mul_last = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));
    assign prod_nxt = mplier[0] ? (prod + mcand) : prod;

    // Single-cycle result and carry/overflow, computed from the live operands at accept
    always_comb begin
        sum  = {1'b0, acc} + {1'b0, alu_operand};
        diff = {1'b0, acc} - {1'b0, alu_operand};
        res_d = acc;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (acc[WIDTH-1] == alu_operand[WIDTH-1]) &&
                        (sum[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff[WIDTH-1:0];
                c_d   = diff[WIDTH];   // borrow out of the extended subtract
                v_d   = (acc[WIDTH-1] != alu_operand[WIDTH-1]) &&
                        (diff[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_AND:  res_d = acc & alu_operand;
            OP_OR:   res_d = acc | alu_operand;
            OP_XOR:  res_d = acc ^ alu_operand;
            default: res_d = acc;      // PASS and the reserved opcode
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start outside IDLE is dropped, not queued
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (alu_op == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state == S_MUL);
        done = (state == S_DONE);
    end

    // Multiplier datapath: operands captured at accept, one shift-add per MUL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (accept && alu_op == OP_MUL) begin
            mcand  <= {{WIDTH{1'b0}}, acc};
            mplier <= alu_operand;
            prod   <= '0;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result/flags: loaded on the edge that enters DONE, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            flag_z <= 1'b1;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (accept && alu_op != OP_MUL) begin
            result <= res_d;
            flag_z <= (res_d == '0);
            flag_n <= res_d[WIDTH-1];
            flag_c <= c_d;
            flag_v <= v_d;
        end else if (mul_last) begin
            result <= prod_nxt[WIDTH-1:0];
            flag_z <= (prod_nxt[WIDTH-1:0] == '0);
            flag_n <= prod_nxt[WIDTH-1];
            flag_c <= |prod_nxt[2*WIDTH-1:WIDTH];
            flag_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8) with hand-computed expectations.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       alu_en;
    logic [2:0] alu_op;
    logic [7:0] acc;
    logic [7:0] alu_operand;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       flag_z, flag_n, flag_c, flag_v;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_en(alu_en),
        .alu_op(alu_op), .acc(acc), .alu_operand(alu_operand),
        .busy(busy), .done(done), .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {Z,N,C,V}
    function automatic logic [3:0] flags();
        return {flag_z, flag_n, flag_c, flag_v};
    endfunction

    // Issue a single-cycle op and check the done cycle and the one after
    task automatic single_op(input string tag, input logic [2:0] op,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_res, input logic [3:0] exp_fl);
        alu_op = op; acc = a; alu_operand = b; alu_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_res"}, {8'd0, result}, {8'd0, exp_res});
        chk({tag, "_flags"}, {12'd0, flags()}, {12'd0, exp_fl});
        tick();
        chk({tag, "_done_low"}, {15'd0, done}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_en = 1'b0; alu_op = 3'b000;
        acc = 8'h00; alu_operand = 8'h00;
        tick(); tick();
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_res", {8'd0, result}, 16'h0000);
        chk("rst_flags", {12'd0, flags()}, 16'h0008);
        rst_n = 1'b1;
        tick();

        // Single-cycle ops
        single_op("add_ovf", 3'b001, 8'h7F, 8'h01, 8'h80, 4'b0101);
        single_op("add_carry", 3'b001, 8'hFF, 8'h01, 8'h00, 4'b1010);
        single_op("sub_borrow", 3'b010, 8'h03, 8'h05, 8'hFE, 4'b0110);
        single_op("sub_vflag", 3'b010, 8'h80, 8'h01, 8'h7F, 4'b0001);
        single_op("and", 3'b011, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        single_op("or", 3'b100, 8'hF0, 8'h3C, 8'hFC, 4'b0100);
        single_op("xor", 3'b101, 8'hF0, 8'h3C, 8'hCC, 4'b0100);
        single_op("pass", 3'b000, 8'h5A, 8'h33, 8'h5A, 4'b0000);
        single_op("reserved", 3'b111, 8'hA5, 8'h33, 8'hA5, 4'b0100);

        // MUL with input changes and a stray start while busy
        alu_op = 3'b110; acc = 8'h0C; alu_operand = 8'h0B; start = 1'b1;
        tick();
        start = 1'b0; acc = 8'hFF; alu_operand = 8'hFF; alu_op = 3'b001;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("mul_busy_c%0d", i), {14'd0, busy, done}, 16'h0002);
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        chk("mul_done", {14'd0, busy, done}, 16'h0001);
        chk("mul_res", {8'd0, result}, 16'h0084);
        chk("mul_flags", {12'd0, flags()}, 16'h0004);
        tick();
        chk("mul_after_done", {15'd0, done}, 16'd0);
        chk("mul_res_hold", {8'd0, result}, 16'h0084);

        // MUL overflow
        alu_op = 3'b110; acc = 8'h10; alu_operand = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mul_ovf_done", {15'd0, done}, 16'd1);
        chk("mul_ovf_res", {8'd0, result}, 16'h0000);
        chk("mul_ovf_flags", {12'd0, flags()}, 16'h000A);
        tick();

        // start held into the DONE cycle is ignored
        alu_op = 3'b001; acc = 8'h01; alu_operand = 8'h01; start = 1'b1;
        tick();
        chk("hold_start_done", {15'd0, done}, 16'd1);
        chk("hold_start_res", {8'd0, result}, 16'h0002);
        tick();
        start = 1'b0;
        chk("hold_start_nodone", {14'd0, busy, done}, 16'h0000);
        tick();
        chk("hold_start_idle", {14'd0, busy, done}, 16'h0000);

        // Enable gating
        alu_en = 1'b0; alu_op = 3'b001; acc = 8'h40; alu_operand = 8'h01; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("gate_nodone_%0d", i), {14'd0, busy, done}, 16'h0000);
            chk($sformatf("gate_res_%0d", i), {8'd0, result}, 16'h0002);
        end
        start = 1'b0; alu_en = 1'b1;

        // Async reset mid-MUL at iteration 3
        alu_op = 3'b110; acc = 8'h03; alu_operand = 8'h05; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", {15'd0, busy}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy_done", {14'd0, busy, done}, 16'h0000);
        chk("async_rst_res", {8'd0, result}, 16'h0000);
        chk("async_rst_flags", {12'd0, flags()}, 16'h0008);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("post_rst_nodone_%0d", i), {15'd0, done}, 16'd0);
        end

        // Next op after the aborted MUL runs normally
        alu_op = 3'b110; acc = 8'h03; alu_operand = 8'h05; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mul2_done", {15'd0, done}, 16'd1);
        chk("mul2_res", {8'd0, result}, 16'h000F);
        chk("mul2_flags", {12'd0, flags()}, 16'h0000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
